// File: rtl/rcn_pkg.sv
// Shared definitions for RCN ring nodes: packet layout, field widths and
// the per-requester slot state used by the master arbiter.
package rcn_pkg;

    // Packet geometry
    localparam int RCN_W   = 67;
    localparam int ID_W    = 6;
    localparam int ADDR_W  = 22;
    localparam int MASK_W  = 4;
    localparam int DATA_W  = 32;

    // Field bit positions inside a ring packet
    localparam int VALID   = 66;
    localparam int REQ     = 65;
    localparam int ID_HI   = 64;
    localparam int ID_LO   = 59;
    localparam int WR      = 58;
    localparam int MASK_HI = 57;
    localparam int MASK_LO = 54;
    localparam int ADDR_HI = 53;
    localparam int ADDR_LO = 32;
    localparam int DATA_HI = 31;
    localparam int DATA_LO = 0;

    // Structured view of a ring packet; field order matches the bit positions above
    typedef struct packed {
        logic              valid;
        logic              req;
        logic [ID_W-1:0]   id;
        logic              wr;
        logic [MASK_W-1:0] mask;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } rcn_pkt_t;

    // Lifecycle of one requester's transaction
    typedef enum logic [1:0] {
        SLOT_IDLE        = 2'd0,
        SLOT_PENDING     = 2'd1,
        SLOT_OUTSTANDING = 2'd2
    } slot_state_t;

    // Build a valid request packet from its fields
    function automatic logic [RCN_W-1:0] rcn_make_req(
        input logic [ID_W-1:0]   id,
        input logic              wr,
        input logic [MASK_W-1:0] mask,
        input logic [ADDR_W-1:0] addr,
        input logic [DATA_W-1:0] data
    );
        rcn_pkt_t pkt;
        pkt.valid = 1'b1;
        pkt.req   = 1'b1;
        pkt.id    = id;
        pkt.wr    = wr;
        pkt.mask  = mask;
        pkt.addr  = addr;
        pkt.data  = data;
        return pkt;
    endfunction

endpackage

// File: rtl/rcn_rr_arb.sv
// Round-robin arbiter: picks the first requesting line at or after the
// pointer; the pointer advances past the winner whenever a grant is made.
module rcn_rr_arb
    import rcn_pkg::*;
#(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] req,
    input  logic         en,
    output logic [N-1:0] grant
);

    localparam int PTR_W = (N > 1) ? $clog2(N) : 1;

    logic [PTR_W-1:0] ptr_reg;
    logic [PTR_W-1:0] ptr_next;
    logic [PTR_W-1:0] scan_idx;
    logic             found;

    // Rotating priority search starting at the pointer
    always_comb begin
        grant    = '0;
        found    = 1'b0;
        ptr_next = ptr_reg;
        scan_idx = '0;
        for (int k = 0; k < N; k++) begin
            scan_idx = PTR_W'((int'(ptr_reg) + k) % N);
            if (en && !found && req[scan_idx]) begin
                found           = 1'b1;
                grant[scan_idx] = 1'b1;
                ptr_next        = (scan_idx == PTR_W'(N - 1)) ? '0 : scan_idx + 1'b1;
            end
        end
    end

    // Pointer register, only moves on an actual grant
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_reg <= '0;
        end else begin
            ptr_reg <= ptr_next;
        end
    end

endmodule

// File: rtl/rcn_master_arb.sv
// Shares a single RCN ring master node among NUM_REQ local requesters.
// Requester i owns ring ID MASTER_ID+i, so responses find their way home
// by ID alone. The node adds one register stage to the ring.
module rcn_master_arb
    import rcn_pkg::*;
#(
    parameter int         NUM_REQ   = 4,
    parameter logic [5:0] MASTER_ID = 6'd0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [RCN_W-1:0]        rcn_in,
    output logic [RCN_W-1:0]        rcn_out,
    input  logic [NUM_REQ-1:0]      req_cs,
    input  logic [NUM_REQ-1:0]      req_wr,
    input  logic [NUM_REQ*24-1:0]   req_addr,
    input  logic [NUM_REQ*4-1:0]    req_mask,
    input  logic [NUM_REQ*32-1:0]   req_wdata,
    output logic [NUM_REQ-1:0]      req_busy,
    output logic [NUM_REQ-1:0]      req_done,
    output logic [NUM_REQ*32-1:0]   req_rdata
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    // Incoming packet decode
    rcn_pkt_t    in_pkt;
    logic [1:0]  in_slot;
    logic        consume;
    logic        ring_free;

    // Per-slot storage
    slot_state_t       state_reg [NUM_REQ];
    logic              wr_reg    [NUM_REQ];
    logic [MASK_W-1:0] mask_reg  [NUM_REQ];
    logic [ADDR_W-1:0] addr_reg  [NUM_REQ];
    logic [DATA_W-1:0] wdata_reg [NUM_REQ];
    logic [DATA_W-1:0] rdata_reg [NUM_REQ];
    logic [NUM_REQ-1:0] done_reg;

    // Arbitration and issue
    logic [NUM_REQ-1:0] pending;
    logic [NUM_REQ-1:0] grant;
    logic [IDX_W-1:0]   gnt_idx;
    logic               issue;
    logic [RCN_W-1:0]   issue_pkt;
    logic [RCN_W-1:0]   rcn_out_reg;

    assign in_pkt  = rcn_pkt_t'(rcn_in);
    assign in_slot = in_pkt.id[1:0];

    // A response is ours when the upper ID bits match our base and the low bits name an existing requester
    assign consume   = in_pkt.valid && !in_pkt.req
                    && (in_pkt.id[5:2] == MASTER_ID[5:2])
                    && (int'(in_slot) < NUM_REQ);

    // The outgoing ring slot is usable if nothing arrived, or what arrived is being removed
    assign ring_free = !in_pkt.valid || consume;

    rcn_rr_arb #(
        .N (NUM_REQ)
    ) u_arb (
        .clk   (clk),
        .rst   (rst),
        .req   (pending),
        .en    (ring_free),
        .grant (grant)
    );

    assign issue = |grant;

    // One-hot grant to slot index
    always_comb begin
        gnt_idx = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                gnt_idx = IDX_W'(i);
            end
        end
    end

    // Request packet for the granted slot; low ID bits carry the slot number
    assign issue_pkt = rcn_make_req(MASTER_ID + ID_W'(gnt_idx),
                                    wr_reg[gnt_idx],
                                    mask_reg[gnt_idx],
                                    addr_reg[gnt_idx],
                                    wdata_reg[gnt_idx]);

    // Ring output stage: own request wins a free slot, consumed packets vanish, everything else passes
    always_ff @(posedge clk) begin
        if (rst) begin
            rcn_out_reg <= '0;
        end else if (issue) begin
            rcn_out_reg <= issue_pkt;
        end else if (consume) begin
            rcn_out_reg <= '0;
        end else begin
            rcn_out_reg <= rcn_in;
        end
    end

    // Slot state machines: accept when idle, issue when granted, retire on matching response
    always_ff @(posedge clk) begin
        if (rst) begin
            done_reg <= '0;
            for (int i = 0; i < NUM_REQ; i++) begin
                state_reg[i] <= SLOT_IDLE;
                rdata_reg[i] <= '0;
            end
        end else begin
            done_reg <= '0;
            for (int i = 0; i < NUM_REQ; i++) begin
                case (state_reg[i])
                    SLOT_IDLE: begin
                        if (req_cs[i]) begin
                            state_reg[i] <= SLOT_PENDING;
                            wr_reg[i]    <= req_wr[i];
                            mask_reg[i]  <= req_mask[4*i +: 4];
                            addr_reg[i]  <= req_addr[24*i+2 +: 22];
                            wdata_reg[i] <= req_wdata[32*i +: 32];
                        end
                    end
                    SLOT_PENDING: begin
                        if (grant[i]) begin
                            state_reg[i] <= SLOT_OUTSTANDING;
                        end
                    end
                    SLOT_OUTSTANDING: begin
                        if (consume && (in_slot == 2'(i))) begin
                            state_reg[i] <= SLOT_IDLE;
                            done_reg[i]  <= 1'b1;
                            rdata_reg[i] <= in_pkt.data;
                        end
                    end
                    default: begin
                        state_reg[i] <= SLOT_IDLE;
                    end
                endcase
            end
        end
    end

    // Per-requester status and data fan-out
    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_slot
            assign pending[gi]              = (state_reg[gi] == SLOT_PENDING);
            assign req_busy[gi]             = (state_reg[gi] != SLOT_IDLE);
            assign req_rdata[32*gi +: 32]   = rdata_reg[gi];
        end
    endgenerate

    assign req_done = done_reg;
    assign rcn_out  = rcn_out_reg;

endmodule
